// File: rtl/icache_dm_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_dm_pkg;

    // Default geometry: 16 one-word frames over a 32-bit byte address.
    localparam int ISETS   = 16;
    localparam int IWORD_W = 32;
    localparam int IIDX_W  = $clog2(ISETS);
    localparam int ITAG_W  = IWORD_W - IIDX_W - 2;

    // Fetch address split for the default geometry.
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    // Cache controller states.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_frames.sv
// Valid/tag/data storage for the instruction cache: one write port, one async read port.
module icache_frames #(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 26,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wen,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic              rvalid,
    output logic [TAG_W-1:0]  rtag,
    output logic [WORD_W-1:0] rdata
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [WORD_W-1:0] data_q [SETS];

    // Valid bits are the only state that must be cleared; a frame only becomes valid once fully written.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (wen) begin
            valid_q[widx] <= 1'b1;
        end
    end

    // Tag and data payload, written together with the valid bit; no reset needed.
    always_ff @(posedge CLK) begin
        if (wen) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-block instruction cache with hit/miss performance counters.
//
// state | meaning
// IDLE  | serving fetches from the frames; a miss (when not halted) starts a fill
// FILL  | reading the latched word address from memory until iwait drops
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int SETS   = ISETS,
    parameter int WORD_W = IWORD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] imemload,
    output logic              ihit,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic [WORD_W-1:0] iload,
    input  logic              iwait,
    input  logic              halt,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    icache_state_t     state_q, state_d;
    logic [WORD_W-3:0] fill_word_q;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              frame_valid;
    logic [TAG_W-1:0]  frame_tag;
    logic [WORD_W-1:0] frame_data;
    logic              hit;
    logic              start_fill;
    logic              fill_done;
    logic              unused_bytoff;

    assign req_tag       = imemaddr[WORD_W-1:IDX_W+2];
    assign req_idx       = imemaddr[IDX_W+1:2];
    assign unused_bytoff = ^imemaddr[1:0];

    icache_frames #(
        .SETS   (SETS),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .WORD_W (WORD_W)
    ) u_frames (
        .CLK    (CLK),
        .RST    (RST),
        .wen    (fill_done),
        .widx   (fill_word_q[IDX_W-1:0]),
        .wtag   (fill_word_q[WORD_W-3:IDX_W]),
        .wdata  (iload),
        .ridx   (req_idx),
        .rvalid (frame_valid),
        .rtag   (frame_tag),
        .rdata  (frame_data)
    );

    // Hits are only served from IDLE; during a fill the frames may be mid-update.
    assign hit      = (state_q == IDLE) && imemREN && frame_valid && (frame_tag == req_tag);
    assign ihit     = hit;
    assign imemload = hit ? frame_data : '0;
    assign iREN     = (state_q == FILL);
    assign iaddr    = {fill_word_q, 2'b00};

    // State register; reset drops iREN immediately even mid-fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fills run to completion regardless of redirects or halt.
    always_comb begin
        state_d    = state_q;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit && !halt) begin
                    start_fill = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (!iwait) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill address latch: the fill uses this word address only, so later redirects cannot corrupt it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fill_word_q <= '0;
        end else if (start_fill) begin
            fill_word_q <= imemaddr[WORD_W-1:2];
        end
    end

    // Performance counters: misses count fill starts, hits count unhalted hit cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (start_fill) begin
                miss_count <= sat_inc(miss_count);
            end
            if (hit && !halt) begin
                hit_count <= sat_inc(hit_count);
            end
        end
    end

endmodule
